// File: rtl/id_inst_queue.sv
// Instruction queue between fetch and decode: pairs each fetch PC with the SRAM word
// returning one cycle later and buffers up to DEPTH entries, with flush and empty-bypass.
module id_inst_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_pc,
    output logic                       req_ready,
    input  logic [INST_W-1:0]          inst_sram_rdata,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic have_head;
    logic accept;
    logic byp_avail;
    logic byp_take;
    logic enq;
    logic deq;

    // Credit check: every accepted fetch has a slot reserved for its returning word.
    assign req_ready = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
    assign count     = count_q;

    // Handshake decode; flush overrides enqueue, dequeue and bypass.
    always_comb begin
        have_head = (count_q != '0);
        accept    = req_valid && req_ready;
        byp_avail = (BYPASS != 0) && !have_head && inflight_q;
        byp_take  = byp_avail && out_ready && !flush;
        enq       = inflight_q && !flush && !byp_take;
        deq       = have_head && out_ready && !flush;
    end

    // Head entry when stored, otherwise the arriving word when bypass is enabled.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        if (!flush) begin
            if (have_head) begin
                out_valid = 1'b1;
                out_pc    = pc_mem_q[head_q];
                out_inst  = inst_mem_q[head_q];
            end else if (byp_avail) begin
                out_valid = 1'b1;
                out_pc    = pc_q;
                out_inst  = inst_sram_rdata;
            end
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = accept;
        pc_d       = accept ? req_pc : pc_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq);
            tail_d  = tail_q + PTR_W'(enq);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[tail_q]   <= pc_q;
            inst_mem_q[tail_q] <= inst_sram_rdata;
        end
    end

endmodule
